xcvr_dir_ctl: RTL
=================

# xcvr_dir_ctl

Direction and enable sequencer for the octal bidirectional bus transceiver bank between the local data bus (A side) and the system bus (B side). Arbitrates two requesters, CPU (port 0) and DMA (port 1), drives the active-low transmit (A->B) and receive (B->A) enables, and guarantees both directions are never enabled together. Every hand-over between owners or directions passes through a programmable all-off turnaround gap. Sits beside the transceiver bank in the bus interface; its enable outputs connect directly to the transceiver T_n/R_n pins.

## Interface
- TURN_CYCLES, 1, all-off cycles inserted after every release (legal range 1..15).
- MAX_HOLD, 0, maximum ACTIVE cycles per grant before forced release; 0 disables the timeout.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  level request from CPU / DMA; held high until the transfer is done.
- dir0 / dir1  input  1  requested direction: 1 = transmit (A->B), 0 = receive (B->A); sampled at grant only.
- ack0 / ack1  output  1  high while that requester owns an enabled transceiver.
- t_n  output  1  transmit enable, active low.
- r_n  output  1  receive enable, active low.
- busy  output  1  high in ACTIVE or TURN.
- owner  output  1  current or most recent owner (0 = CPU, 1 = DMA).
- timeout  output  1  one-cycle pulse when MAX_HOLD forces a release.

## Operation
- States: IDLE, ACTIVE, TURN. All outputs registered.
- IDLE: if any eligible request is high, grant it and go to ACTIVE. Latch owner and the winner's dir. Set ack(owner)=1. Drive t_n=0 if dir=1, otherwise r_n=0.
- Arbitration is round robin. If both requesters are eligible, grant the one that is not last_owner. last_owner resets to 1, so the CPU wins the first contested grant.
- ACTIVE:
  - Enables and ack hold. Changes on dir are ignored until the next grant.
  - When req(owner) is sampled low: go to TURN, set ack=0, t_n=1, r_n=1, and load turn_cnt=TURN_CYCLES.
- Hold counter: counts ACTIVE cycles, starting at 1 on the first ACTIVE cycle.
  - If MAX_HOLD!=0 and the counter reaches MAX_HOLD while req is still high, release exactly as above and pulse timeout for 1 cycle.
  - That requester is then masked (ineligible) until its req is sampled low.
- TURN: decrement turn_cnt each cycle with t_n=r_n=1. On the cycle turn_cnt reaches 1, evaluate arbitration exactly as in IDLE. Grant directly into ACTIVE, or go to IDLE if nothing is eligible.
- Invariants, checked every cycle:
  - (t_n|r_n)==1.
  - At most one ack is high.
  - ack(x)=1 implies exactly one enable is low.
  - Between any two enabled intervals there are at least TURN_CYCLES cycles with t_n=r_n=1.
- Reset, asserted at any edge in any state:
  - Next-cycle outputs: t_n=1, r_n=1, ack0=ack1=0, busy=0, owner=0, timeout=0.
  - Internal: state=IDLE, last_owner=1, masks cleared, counters 0.
  - No turnaround is owed after reset.

## Timing
- Grant latency from IDLE: req high before edge k -> ack and enable asserted after edge k (1 cycle).
- Release latency: req low before edge m -> ack=0 and enables high after edge m.
- Back-to-back with the other requester pending: enables are off for exactly TURN_CYCLES cycles. The next owner's ack and enable assert after edge m+TURN_CYCLES.
- Same requester re-requesting: it is treated the same as any other request after TURN.
  - Round robin applies only when both requesters are eligible.
  - A lone requester is always granted.
- A request that drops before being granted is simply not granted. There is no latching of pulses.
- A request arriving during TURN waits until TURN ends. A request arriving in the final TURN cycle is granted at that edge.
- Timeout: with MAX_HOLD=N, enables stay low for exactly N cycles. The timeout pulse coincides with the first all-off cycle.

## Test plan
- Reset then req0=1, dir0=1 -> one cycle later ack0=1, t_n=0, r_n=1, owner=0. Drop req0 -> next cycle ack0=0, t_n=r_n=1, busy=1 for TURN_CYCLES cycles, then busy=0.
- req0 and req1 raised in the same cycle, TURN_CYCLES=2 -> CPU granted first. On CPU release there are exactly 2 cycles with t_n=r_n=1, then ack1=1 with the DMA direction.
- Direction flip by the same owner: grant dir0=0 (r_n=0), toggle dir0 mid-grant -> r_n stays 0. Release and re-request with dir0=1 -> t_n=0 only after the TURN gap.
- MAX_HOLD=4, req1 held high -> t_n or r_n low for exactly 4 cycles, timeout pulses once, and req1 is not regranted until it drops and rises again. A pending req0 is granted after TURN.
- reset asserted in ACTIVE and again in TURN -> next cycle t_n=r_n=1, acks 0, busy 0. A subsequent contested request goes to the CPU.
- Randomized req/dir streams for 10k cycles: the invariant checker never fires, and round robin alternates under continuous contention.

Source files
------------

// File: rtl/xcvr_dir_ctl_if.sv
// Request/direction inputs and transceiver enable/acknowledge outputs of the
// direction sequencer, grouped for the requester side (master) and the sequencer (slave).
interface xcvr_dir_ctl_if;
   logic req0;
   logic req1;
   logic dir0;
   logic dir1;
   logic ack0;
   logic ack1;
   logic t_n;
   logic r_n;
   logic busy;
   logic owner;
   logic timeout;

   modport master (
      output req0, req1, dir0, dir1,
      input  ack0, ack1, t_n, r_n, busy, owner, timeout
   );

   modport slave (
      input  req0, req1, dir0, dir1,
      output ack0, ack1, t_n, r_n, busy, owner, timeout
   );
endinterface

// File: rtl/xcvr_dir_ctl.sv
// Transceiver direction/enable sequencer: round-robin CPU/DMA arbitration with a
// programmable all-off turnaround gap between every hand-over and an optional hold timeout.
module xcvr_dir_ctl #(
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned MAX_HOLD    = 0
) (
   input logic           clk,
   input logic           reset,
   xcvr_dir_ctl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_TURN   = 2'd2
   } state_e;

   localparam int unsigned HOLD_W = (MAX_HOLD < 32'd2) ? 1 : $clog2(MAX_HOLD + 32'd1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic [3:0]        TURN_VAL = 4'(TURN_CYCLES);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              t_n_q, t_n_d;
   logic              r_n_q, r_n_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [3:0]        turn_q, turn_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        mask_q, mask_d;

   logic [1:0] elig_s;
   logic       win_s;
   logic       win_dir_s;
   logic       req_own_s;
   logic       grant_s;
   logic       release_s;

   // A masked requester stays ineligible until its request has been seen low.
   assign elig_s    = {bus.req1 & ~mask_q[1], bus.req0 & ~mask_q[0]};
   assign win_s     = (elig_s == 2'b11) ? ~last_owner_q : elig_s[1];
   assign win_dir_s = win_s ? bus.dir1 : bus.dir0;
   assign req_own_s = owner_q ? bus.req1 : bus.req0;

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      ack0_d       = ack0_q;
      ack1_d       = ack1_q;
      t_n_d        = t_n_q;
      r_n_d        = r_n_q;
      busy_d       = busy_q;
      timeout_d    = 1'b0;
      turn_d       = turn_q;
      hold_d       = hold_q;
      mask_d       = mask_q & {bus.req1, bus.req0};
      grant_s      = 1'b0;
      release_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (elig_s != 2'b00) begin
               grant_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (!req_own_s) begin
               release_s = 1'b1;
            end else if ((MAX_HOLD != 32'd0) && (hold_q == HOLD_MAX)) begin
               release_s       = 1'b1;
               timeout_d       = 1'b1;
               mask_d[owner_q] = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         ST_TURN: begin
            if (turn_q > 4'd1) begin
               turn_d = turn_q - 4'd1;
            end else if (elig_s != 2'b00) begin
               grant_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            t_n_d   = 1'b1;
            r_n_d   = 1'b1;
         end
      endcase

      if (grant_s) begin
         state_d      = ST_ACTIVE;
         owner_d      = win_s;
         last_owner_d = win_s;
         ack0_d       = ~win_s;
         ack1_d       = win_s;
         t_n_d        = ~win_dir_s;
         r_n_d        = win_dir_s;
         busy_d       = 1'b1;
         hold_d       = HOLD_ONE;
      end else if (release_s) begin
         state_d = ST_TURN;
         ack0_d  = 1'b0;
         ack1_d  = 1'b0;
         t_n_d   = 1'b1;
         r_n_d   = 1'b1;
         busy_d  = 1'b1;
         turn_d  = TURN_VAL;
      end else begin
         busy_d = (state_d != ST_IDLE);
      end
   end

   // State and output registers; reset leaves both enables off with no turnaround owed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         t_n_q        <= 1'b1;
         r_n_q        <= 1'b1;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         turn_q       <= 4'd0;
         hold_q       <= '0;
         mask_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         t_n_q        <= t_n_d;
         r_n_q        <= r_n_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
         turn_q       <= turn_d;
         hold_q       <= hold_d;
         mask_q       <= mask_d;
      end
   end

   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.t_n     = t_n_q;
   assign bus.r_n     = r_n_q;
   assign bus.busy    = busy_q;
   assign bus.owner   = owner_q;
   assign bus.timeout = timeout_q;

endmodule
